approx_umul_pipe: RTL

//  Parametrised, pipelined unsigned WxW multiplier with a runtime-selectable

---
 rtl/approx_umul_pipe.sv | 120 ++++++++++++
 1 files changed

// File: rtl/approx_umul_pipe.sv
// approx_umul_pipe
//   Two-stage pipelined unsigned W x W multiplier with a per-transaction
//   approximate mode and valid/ready flow control on both sides.
//   Approximate mode keeps all partial-product rows of x from bit L upward.
//   From the lowest L rows it keeps only the bits of weight 2^W and above.
//   Exact mode, or L = 0, returns the full product.
//
// Parameters
//   W  operand width (W >= 2); the result is 2W bits wide
//   L  number of approximated low rows of x (0 <= L < W)
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   x/y/mode present this cycle
//   in_ready   out  stage can accept; a beat transfers on in_valid & in_ready
//   in_x       in   multiplicand, unsigned, W bits
//   in_y       in   multiplier, unsigned, W bits
//   in_approx  in   1 = approximate product, 0 = exact product
//   out_valid  out  out_z holds a result
//   out_ready  in   consumer accepts; a beat transfers on out_valid & out_ready
//   out_z      out  product, 2W bits
//   out_approx out  mode of the transaction currently on out_z
module approx_umul_pipe #(
    parameter int unsigned W = 8,
    parameter int unsigned L = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_x,
    input  logic [W-1:0]   in_y,
    input  logic           in_approx,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_z,
    output logic           out_approx
);

    localparam int unsigned ZW = 2 * W;

    logic          adv1, adv2, in_fire;
    logic [ZW-1:0] hi_d, low_d, z_d;
    logic [ZW-1:0] hi_q, low_q;
    logic          s1_valid_q, s1_approx_q;
    logic [ZW-1:0] out_z_q;
    logic          out_valid_q, out_approx_q;

    // Flow control: each stage may advance when it is empty or its consumer
    // drains it this cycle. in_ready is combinational from out_ready.
    always_comb begin
        adv2     = !out_valid_q || out_ready;
        adv1     = !s1_valid_q || adv2;
        in_ready = adv1;
        in_fire  = in_valid && in_ready;
    end

    // Rows of x at and above bit L are always computed exactly.
    always_comb begin
        hi_d = (ZW'(in_y) * ZW'(in_x >> L)) << L;
    end

    // Low-row term: the full low rows in exact mode, otherwise only the
    // partial-product bits whose weight i+j reaches W.
    always_comb begin
        low_d = '0;
        for (int i = 0; i < int'(L); i++) begin
            if (in_x[i]) begin
                if (in_approx) begin
                    for (int j = 0; j < int'(W); j++) begin
                        if (in_y[j] && (i + j >= int'(W))) begin
                            low_d = low_d + (ZW'(1) << (i + j));
                        end
                    end
                end else begin
                    low_d = low_d + (ZW'(in_y) << i);
                end
            end
        end
    end

    // The sum cannot overflow 2W bits: it never exceeds the exact product.
    always_comb begin
        z_d = hi_q + low_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_approx_q  <= 1'b0;
            hi_q         <= '0;
            low_q        <= '0;
            out_valid_q  <= 1'b0;
            out_z_q      <= '0;
            out_approx_q <= 1'b0;
        end else begin
            if (adv1) begin
                s1_valid_q <= in_valid;
            end
            if (in_fire) begin
                hi_q        <= hi_d;
                low_q       <= low_d;
                s1_approx_q <= in_approx;
            end
            if (adv2) begin
                out_valid_q  <= s1_valid_q;
                out_z_q      <= z_d;
                out_approx_q <= s1_approx_q;
            end
        end
    end

    always_comb begin
        out_valid  = out_valid_q;
        out_z      = out_z_q;
        out_approx = out_approx_q;
    end

endmodule
